// File: rtl/gsim_pkg.sv
// Shared types and constants for the Gauss-Seidel solver controller and datapath.
package gsim_pkg;

   localparam int GSIM_N        = 16;
   localparam int GSIM_IDX_W    = 4;
   localparam int GSIM_PIPE_LAT = 4;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      SWEEP  = 2'd1,
      OUTPUT = 2'd2,
      DONE   = 2'd3
   } gsim_state_e;

endpackage

// File: rtl/gsim_phase_cnt.sv
// Modulo-PIPE_LAT phase counter with registered issue (phase 0) and last-phase strobes.
module gsim_phase_cnt
   import gsim_pkg::*;
#(
   parameter int PIPE_LAT = GSIM_PIPE_LAT
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic run,
   output logic issue,
   output logic last
);

   localparam int PH_W = $clog2(PIPE_LAT);

   logic [PH_W-1:0] ph_r;
   logic [PH_W-1:0] ph_nx_s;
   logic            issue_nx_s;
   logic            last_nx_s;

   // Next phase: start forces phase 0, run advances modulo PIPE_LAT, otherwise idle.
   always_comb begin
      ph_nx_s    = {PH_W{1'b0}};
      issue_nx_s = 1'b0;
      last_nx_s  = 1'b0;
      if (start) begin
         ph_nx_s    = {PH_W{1'b0}};
         issue_nx_s = 1'b1;
      end else if (run) begin
         if (ph_r == PH_W'(PIPE_LAT - 1)) begin
            ph_nx_s    = {PH_W{1'b0}};
            issue_nx_s = 1'b1;
         end else begin
            ph_nx_s    = ph_r + PH_W'(1);
            issue_nx_s = 1'b0;
         end
         last_nx_s = (ph_r == PH_W'(PIPE_LAT - 2));
      end else begin
         ph_nx_s = {PH_W{1'b0}};
      end
   end

   // Phase register and strobe flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ph_r  <= {PH_W{1'b0}};
         issue <= 1'b0;
         last  <= 1'b0;
      end else begin
         ph_r  <= ph_nx_s;
         issue <= issue_nx_s;
         last  <= last_nx_s;
      end
   end

endmodule

// File: rtl/gsim_sweep_ctrl.sv
// Gauss-Seidel sweep sequencer: RHS load, serialized updates, convergence detect, read-out.
// Optional sweep cap is enabled by defining GSIM_ITER_CAP_EN.
module gsim_sweep_ctrl
   import gsim_pkg::*;
#(
   parameter int N        = GSIM_N,
   parameter int IDX_W    = GSIM_IDX_W,
   parameter int PIPE_LAT = GSIM_PIPE_LAT,
   parameter int MAX_ITER = 100,
   parameter int ITER_W   = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_en,
   output logic              in_ready,
   output logic              ld_we,
   output logic [IDX_W-1:0]  ld_idx,
   output logic              dp_issue,
   output logic              dp_wr,
   output logic [IDX_W-1:0]  dp_idx,
   input  logic              dp_same,
   output logic              out_valid,
   output logic [IDX_W-1:0]  out_idx,
   output logic              done,
   output logic              converged,
   output logic [ITER_W-1:0] iter_cnt
);

`ifdef GSIM_ITER_CAP_EN
   localparam logic CAP_EN = 1'b1;
`else
   localparam logic CAP_EN = 1'b0;
`endif

   gsim_state_e      state_r;
   gsim_state_e      state_nx_s;
   logic             in_ready_nx_s;
   logic [IDX_W-1:0] ld_idx_nx_s;
   logic [IDX_W-1:0] dp_idx_nx_s;
   logic [IDX_W-1:0] out_idx_nx_s;
   logic [IDX_W:0]   same_cnt_r;
   logic [IDX_W:0]   same_cnt_nx_s;
   logic [IDX_W:0]   same_sum_s;
   logic [ITER_W-1:0] iter_nx_s;
   logic [ITER_W-1:0] iter_inc_s;
   logic             out_valid_nx_s;
   logic             done_nx_s;
   logic             converged_nx_s;
   logic             ph_start_s;
   logic             ph_run_s;
   logic             sweep_end_s;
   logic             cap_hit_s;

   assign ld_we = in_en & in_ready;

   gsim_phase_cnt #(
      .PIPE_LAT (PIPE_LAT)
   ) u_phase (
      .clk   (clk),
      .reset (reset),
      .start (ph_start_s),
      .run   (ph_run_s),
      .issue (dp_issue),
      .last  (dp_wr)
   );

   // Next-state and next-output logic for the whole sequencer.
   always_comb begin
      state_nx_s     = state_r;
      ld_idx_nx_s    = ld_idx;
      dp_idx_nx_s    = dp_idx;
      out_idx_nx_s   = out_idx;
      same_cnt_nx_s  = same_cnt_r;
      iter_nx_s      = iter_cnt;
      out_valid_nx_s = out_valid;
      done_nx_s      = done;
      converged_nx_s = converged;
      ph_start_s     = 1'b0;
      ph_run_s       = 1'b0;
      same_sum_s     = same_cnt_r + {{IDX_W{1'b0}}, dp_same};
      iter_inc_s     = (iter_cnt == {ITER_W{1'b1}}) ? iter_cnt : iter_cnt + ITER_W'(1);
      sweep_end_s    = dp_wr && (dp_idx == IDX_W'(N - 1));
      cap_hit_s      = CAP_EN && (iter_cnt == ITER_W'(MAX_ITER - 1));

      case (state_r)
         LOAD: begin
            if (ld_we) begin
               ld_idx_nx_s = ld_idx + IDX_W'(1);
               if (ld_idx == IDX_W'(N - 1)) begin
                  state_nx_s = SWEEP;
                  ph_start_s = 1'b1;
               end else begin
                  state_nx_s = LOAD;
               end
            end else begin
               state_nx_s = LOAD;
            end
         end

         SWEEP: begin
            ph_run_s = 1'b1;
            if (sweep_end_s) begin
               dp_idx_nx_s   = {IDX_W{1'b0}};
               same_cnt_nx_s = {(IDX_W + 1){1'b0}};
               if (same_sum_s == (IDX_W + 1)'(N)) begin
                  converged_nx_s = 1'b1;
                  state_nx_s     = OUTPUT;
                  out_valid_nx_s = 1'b1;
                  out_idx_nx_s   = {IDX_W{1'b0}};
                  ph_run_s       = 1'b0;
               end else if (cap_hit_s) begin
                  iter_nx_s      = iter_inc_s;
                  converged_nx_s = 1'b0;
                  state_nx_s     = OUTPUT;
                  out_valid_nx_s = 1'b1;
                  out_idx_nx_s   = {IDX_W{1'b0}};
                  ph_run_s       = 1'b0;
               end else begin
                  iter_nx_s = iter_inc_s;
               end
            end else if (dp_wr) begin
               dp_idx_nx_s   = dp_idx + IDX_W'(1);
               same_cnt_nx_s = same_sum_s;
            end else begin
               same_cnt_nx_s = same_cnt_r;
            end
         end

         OUTPUT: begin
            if (out_idx == IDX_W'(N - 1)) begin
               out_valid_nx_s = 1'b0;
               out_idx_nx_s   = {IDX_W{1'b0}};
               done_nx_s      = 1'b1;
               state_nx_s     = DONE;
            end else begin
               out_idx_nx_s = out_idx + IDX_W'(1);
            end
         end

         DONE: begin
            // A new sample here is accepted as sample 0 of the next problem.
            if (ld_we) begin
               done_nx_s      = 1'b0;
               converged_nx_s = 1'b0;
               iter_nx_s      = {ITER_W{1'b0}};
               same_cnt_nx_s  = {(IDX_W + 1){1'b0}};
               ld_idx_nx_s    = IDX_W'(1);
               state_nx_s     = LOAD;
            end else begin
               state_nx_s = DONE;
            end
         end

         default: begin
            state_nx_s = LOAD;
         end
      endcase

      in_ready_nx_s = (state_nx_s == LOAD) || (state_nx_s == DONE);
   end

   // State register and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= LOAD;
         in_ready   <= 1'b0;
         ld_idx     <= {IDX_W{1'b0}};
         dp_idx     <= {IDX_W{1'b0}};
         out_idx    <= {IDX_W{1'b0}};
         same_cnt_r <= {(IDX_W + 1){1'b0}};
         iter_cnt   <= {ITER_W{1'b0}};
         out_valid  <= 1'b0;
         done       <= 1'b0;
         converged  <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         in_ready   <= in_ready_nx_s;
         ld_idx     <= ld_idx_nx_s;
         dp_idx     <= dp_idx_nx_s;
         out_idx    <= out_idx_nx_s;
         same_cnt_r <= same_cnt_nx_s;
         iter_cnt   <= iter_nx_s;
         out_valid  <= out_valid_nx_s;
         done       <= done_nx_s;
         converged  <= converged_nx_s;
      end
   end

endmodule
